// File: rtl/down_sampler.sv
// down_sampler: 2x decimation of a raster pixel stream; define DOWN_SAMPLE_AVG_EN for 2x2 box averaging
module down_sampler #(
  parameter int IMG_WIDTH = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_valid,
  input  logic [7:0] din,
  output logic       din_ready,
  input  logic       rd_en,
  output logic       valid,
  output logic [7:0] dout,
  output logic       sof
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  typedef enum logic [1:0] {ROW_EVEN, ROW_ODD, FRAME_END} state_t;
  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic xfer, last_col, last_row, emit, first;
  logic [7:0] pix;
  assign din_ready = (state != FRAME_END) && (!valid || rd_en);
  assign xfer = din_valid && din_ready;
  assign last_col = col == CW'(IMG_WIDTH - 1);
  assign last_row = row == RW'(IMG_HEIGHT - 1);
`ifdef DOWN_SAMPLE_AVG_EN
  logic [7:0] held;
  logic [8:0] line_buf [IMG_WIDTH/2];
  logic [8:0] pair_sum;
  logic [9:0] box_sum;
  assign pair_sum = {1'b0, held} + {1'b0, din};
  assign box_sum = {1'b0, line_buf[col[CW-1:1]]} + {1'b0, pair_sum} + 10'd2;
  assign emit = xfer && row[0] && col[0];
  assign pix = box_sum[9:2];
  assign first = row == RW'(1) && col == CW'(1);
  // Even rows leave horizontal pair sums behind for the odd row to finish the box
  always_ff @(posedge clk) begin
    if (xfer && !col[0]) held <= din;
    if (xfer && !row[0] && col[0]) line_buf[col[CW-1:1]] <= pair_sum;
  end
`else
  assign emit = xfer && !row[0] && !col[0];
  assign pix = din;
  assign first = row == '0 && col == '0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ROW_EVEN;
      col <= '0;
      row <= '0;
      valid <= 1'b0;
      dout <= '0;
      sof <= 1'b0;
    end else begin
      if (emit) begin
        valid <= 1'b1;
        dout <= pix;
        sof <= first;
      end else if (rd_en) valid <= 1'b0;
      if (state == FRAME_END) begin
        state <= ROW_EVEN;
        col <= '0;
        row <= '0;
      end else if (xfer) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) begin
          row <= last_row ? '0 : row + 1'b1;
          state <= state == ROW_EVEN ? ROW_ODD : last_row ? FRAME_END : ROW_EVEN;
        end
      end
    end
  end
endmodule

// File: tb/tb_down_sampler.sv
// tb_down_sampler: directed and random stimulus checked against a frame-position reference model
module tb_down_sampler;
  localparam int W = 8, H = 4;
  logic clk = 0, rst = 0, din_valid = 0, rd_en = 0;
  logic din_ready, valid, sof;
  logic [7:0] din = 0, dout;
  int total = 0, bad = 0;
  int pos = 0, frames = 0;
  bit stall_exp = 0;
  logic [8:0] expq [$];
  logic [7:0] seen [$];
  logic [7:0] img [H][W];

  down_sampler #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .rd_en(rd_en), .valid(valid), .dout(dout), .sof(sof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted input pixel at frame position pos; queue the output it produces, if any
  function automatic void accept(input logic [7:0] d);
    int r = pos / W;
    int c = pos % W;
    img[r][c] = d;
`ifdef DOWN_SAMPLE_AVG_EN
    if (r % 2 == 1 && c % 2 == 1)
      expq.push_back({r == 1 && c == 1, 8'((img[r-1][c-1] + img[r-1][c] + img[r][c-1] + d + 2) / 4)});
`else
    if (r % 2 == 0 && c % 2 == 0) expq.push_back({r == 0 && c == 0, d});
`endif
    pos = (pos + 1) % (W * H);
    if (pos == 0) begin
      stall_exp = 1;
      frames++;
    end
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    din_valid = v;
    din = d;
    rd_en = r;
    #1;
    chk("ready", {8'd0, din_ready}, {8'd0, !stall_exp && (expq.size() == 0 || r)});
    chk("valid", {8'd0, valid}, {8'd0, expq.size() != 0});
    if (valid && expq.size() != 0) chk("data", {sof, dout}, expq[0]);
    if (valid && r && expq.size() != 0) begin
      seen.push_back(dout);
      void'(expq.pop_front());
    end
    stall_exp = 0;
    if (v && din_ready) accept(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    chk("rst_valid", {8'd0, valid}, 9'd0);
    pos = 0;
    stall_exp = 0;
    expq.delete();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic run_frames(input int n);
    int tgt = frames + n;
    for (int i = 0; i < 400 && frames < tgt; i++) step(1'b1, 8'(pos), 1'b1);
    chk("frame_timeout", 9'(frames >= tgt), 9'd1);
    step(1'b0, 8'd0, 1'b1);
  endtask

  task automatic check_seen(input string tag, input int n);
    chk({tag, "_count"}, 9'(seen.size()), 9'(n));
`ifndef DOWN_SAMPLE_AVG_EN
    for (int k = 0; k < n && k < seen.size(); k++)
      chk(tag, {1'b0, seen[k]}, 9'(((k % 8) / 4) * 16 + (k % 4) * 2));
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("rst_valid0", {8'd0, valid}, 9'd0);
    chk("rst_dout0", {1'b0, dout}, 9'd0);
    chk("rst_sof0", {8'd0, sof}, 9'd0);
    chk("rst_ready0", {8'd0, din_ready}, 9'd1);
    // Continuous ramp, one frame
    seen.delete();
    run_frames(1);
    check_seen("ramp", 8);
    // Backpressure after the first output
    seen.delete();
    step(1'b1, 8'(pos), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'(pos), 1'b0);
    chk("bp_ready", {8'd0, din_ready}, 9'd0);
    chk("bp_valid", {8'd0, valid}, 9'd1);
    run_frames(1);
    check_seen("bp", 8);
    // Back-to-back frames
    seen.delete();
    run_frames(2);
    check_seen("b2b", 16);
    // Reset with an output pending, then mid-frame after input 13
    step(1'b1, 8'(pos), 1'b0);
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 8'(pos), 1'b1);
    do_reset();
    seen.delete();
    run_frames(1);
    check_seen("post_rst", 8);
    // Random handshake and data, three frames
    begin
      int tgt = frames + 3;
      for (int i = 0; i < 3000 && frames < tgt; i++)
        step(1'($urandom % 2), 8'($urandom), 1'($urandom % 2));
      chk("rand_timeout", 9'(frames >= tgt), 9'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
